// File: rtl/vga_ram_display_module.sv
// vga_ram_display_module: 16x16 RAM bitmap overlay with 3-cycle pixel pipeline and frame-synchronous colour update
// Optional: define VGA_BORDER_EN to draw a 1-pixel FG ring around the bitmap window
module vga_ram_display_module #(
   parameter logic [10:0] X0      = 11'd312,
   parameter logic [10:0] Y0      = 11'd232,
   parameter int          SHIFT   = 2,
   parameter logic [15:0] FG_INIT = 16'hFFFF,
   parameter logic [15:0] BG_INIT = 16'h0000
) (
   input  logic        vga_clk,
   input  logic        rst,
   input  logic        Ready_Sig,
   input  logic        HSYNC_Sig,
   input  logic        VSYNC_Sig,
   input  logic        Frame_Sig,
   input  logic [10:0] Column_Addr_Sig,
   input  logic [10:0] Row_Addr_Sig,
   output logic [3:0]  Ram_Addr,
   input  logic [15:0] Ram_Data,
   input  logic        Cfg_Valid,
   input  logic [15:0] Cfg_Fg,
   input  logic [15:0] Cfg_Bg,
   output logic        Cfg_Ready,
   output logic        VGA_HSYNC,
   output logic        VGA_VSYNC,
   output logic [4:0]  VGA_Red,
   output logic [5:0]  VGA_Green,
   output logic [4:0]  VGA_Blue
);
   typedef enum logic {IDLE, PENDING} state_t;
   state_t state, state_nx;
   logic [11:0] dx, dy, dxs, dys;
   logic in_win, border;
   logic s1_ready, s1_in_win, s1_border, s1_hs, s1_vs;
   logic s2_ready, s2_in_win, s2_border, s2_hs, s2_vs;
   logic [3:0] s1_idx, s2_idx;
   logic [15:0] fg, bg, pend_fg, pend_bg, pix;
   logic frame_q, accept, commit;
   assign dx = {1'b0, Column_Addr_Sig} - {1'b0, X0};
   assign dy = {1'b0, Row_Addr_Sig} - {1'b0, Y0};
   assign dxs = dx >> SHIFT;
   assign dys = dy >> SHIFT;
   // bit 11 is the sign of the 12-bit offset; Ready gates off-screen clipping
   assign in_win = Ready_Sig & ~dx[11] & ~dy[11] & (dxs < 12'd16) & (dys < 12'd16);
`ifdef VGA_BORDER_EN
   localparam logic [11:0] N1 = 12'((16 << SHIFT) + 1);
   logic [11:0] bx, by;
   assign bx = dx + 12'd1;
   assign by = dy + 12'd1;
   // ring is the edge of the square spanning offsets -1..(16<<SHIFT) on both axes
   assign border = Ready_Sig & ~bx[11] & ~by[11] & (bx <= N1) & (by <= N1) &
                   ((bx == 12'd0) | (bx == N1) | (by == 12'd0) | (by == N1));
`else
   assign border = 1'b0;
`endif
   assign pix = ~s2_ready ? 16'h0000 : ((s2_in_win & Ram_Data[s2_idx]) | s2_border) ? fg : bg;
   always_ff @(posedge vga_clk) begin
      if (rst) begin
         s1_ready <= 1'b0;
         s1_in_win <= 1'b0;
         s1_border <= 1'b0;
         s1_idx <= 4'd0;
         s1_hs <= 1'b1;
         s1_vs <= 1'b1;
         Ram_Addr <= 4'd0;
         s2_ready <= 1'b0;
         s2_in_win <= 1'b0;
         s2_border <= 1'b0;
         s2_idx <= 4'd0;
         s2_hs <= 1'b1;
         s2_vs <= 1'b1;
         VGA_HSYNC <= 1'b1;
         VGA_VSYNC <= 1'b1;
         {VGA_Red, VGA_Green, VGA_Blue} <= 16'h0000;
      end else begin
         s1_ready <= Ready_Sig;
         s1_in_win <= in_win;
         s1_border <= border;
         s1_idx <= 4'd15 - dxs[3:0];
         s1_hs <= HSYNC_Sig;
         s1_vs <= VSYNC_Sig;
         Ram_Addr <= in_win ? dys[3:0] : Ram_Addr;
         s2_ready <= s1_ready;
         s2_in_win <= s1_in_win;
         s2_border <= s1_border;
         s2_idx <= s1_idx;
         s2_hs <= s1_hs;
         s2_vs <= s1_vs;
         VGA_HSYNC <= s2_hs;
         VGA_VSYNC <= s2_vs;
         {VGA_Red, VGA_Green, VGA_Blue} <= pix;
      end
   end
   assign Cfg_Ready = (state == IDLE) & ~rst;
   always_comb begin
      accept = (state == IDLE) & Cfg_Valid & Cfg_Ready;
      commit = (state == PENDING) & Frame_Sig & ~frame_q;
      state_nx = accept ? PENDING : commit ? IDLE : state;
   end
   always_ff @(posedge vga_clk) begin
      if (rst) begin
         state <= IDLE;
         frame_q <= 1'b0;
         fg <= FG_INIT;
         bg <= BG_INIT;
         pend_fg <= 16'h0000;
         pend_bg <= 16'h0000;
      end else begin
         state <= state_nx;
         frame_q <= Frame_Sig;
         pend_fg <= accept ? Cfg_Fg : pend_fg;
         pend_bg <= accept ? Cfg_Bg : pend_bg;
         fg <= commit ? pend_fg : fg;
         bg <= commit ? pend_bg : bg;
      end
   end
endmodule

// File: tb/tb_vga_ram_display_module.sv
// tb_vga_ram_display_module: directed and random scans against a pixel-level reference model
module tb_vga_ram_display_module;
   localparam int X0 = 312;
   localparam int Y0 = 232;
   localparam int SHIFT = 2;
   logic vga_clk = 1'b0;
   logic rst = 1'b1, ready = 1'b0, hs = 1'b1, vs = 1'b1, fr = 1'b0, cv = 1'b0;
   logic [10:0] col = 11'd0, row = 11'd0;
   logic [15:0] cf = 16'h0, cb = 16'h0, ram_data = 16'h0;
   logic [3:0] ram_addr;
   logic cfg_ready, o_hs, o_vs;
   logic [4:0] o_r, o_b;
   logic [5:0] o_g;
   logic [15:0] mem [16];
   int errs = 0, checks = 0;
   int kq [3];
   logic hq [3], vq [3];
   logic [3:0] m_addr;
   logic m_idle, m_frp, fstate;
   logic [15:0] m_fg, m_bg, m_pf, m_pb;

   vga_ram_display_module dut (
      .vga_clk(vga_clk), .rst(rst), .Ready_Sig(ready), .HSYNC_Sig(hs), .VSYNC_Sig(vs),
      .Frame_Sig(fr), .Column_Addr_Sig(col), .Row_Addr_Sig(row), .Ram_Addr(ram_addr),
      .Ram_Data(ram_data), .Cfg_Valid(cv), .Cfg_Fg(cf), .Cfg_Bg(cb), .Cfg_Ready(cfg_ready),
      .VGA_HSYNC(o_hs), .VGA_VSYNC(o_vs), .VGA_Red(o_r), .VGA_Green(o_g), .VGA_Blue(o_b));

   always #5 vga_clk = ~vga_clk;
   always @(posedge vga_clk) ram_data <= mem[ram_addr];

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic inwin(input logic rdy, input int c, input int rw);
      int dx, dy;
      dx = c - X0;
      dy = rw - Y0;
      return rdy && dx >= 0 && dy >= 0 && dx < (16 << SHIFT) && dy < (16 << SHIFT);
   endfunction

   // 0 = blank, 1 = background, 2 = foreground
   function automatic int kind(input logic rdy, input int c, input int rw);
      int dx, dy, n;
      logic [15:0] w;
      dx = c - X0;
      dy = rw - Y0;
      n = 16 << SHIFT;
      if (!rdy) return 0;
      if (inwin(rdy, c, rw)) begin
         w = mem[dy / (1 << SHIFT)];
         return w[15 - dx / (1 << SHIFT)] ? 2 : 1;
      end
`ifdef VGA_BORDER_EN
      if (((dx == -1 || dx == n) && dy >= -1 && dy <= n) || ((dy == -1 || dy == n) && dx >= -1 && dx <= n))
         return 2;
`endif
      return 1;
   endfunction

   task automatic model_reset();
      kq = '{0, 0, 0};
      hq = '{1'b1, 1'b1, 1'b1};
      vq = '{1'b1, 1'b1, 1'b1};
      m_addr = 4'd0;
      m_idle = 1'b1;
      m_frp = 1'b0;
      m_fg = 16'hFFFF;
      m_bg = 16'h0000;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ready = 1'b1;
      col = 11'd312;
      row = 11'd232;
      hs = 1'b0;
      vs = 1'b0;
      fr = 1'b0;
      cv = 1'b0;
      repeat (3) begin
         @(posedge vga_clk); #1;
         chk("rst_rgb", {o_r, o_g, o_b}, 16'h0000);
         chk("rst_hsync", 16'(o_hs), 16'h1);
         chk("rst_vsync", 16'(o_vs), 16'h1);
         chk("rst_cfg_ready", 16'(cfg_ready), 16'h0);
         chk("rst_ram_addr", 16'(ram_addr), 16'h0);
      end
      model_reset();
      rst = 1'b0;
      #1;
      chk("cfg_ready_after_rst", 16'(cfg_ready), 16'h1);
   endtask

   task automatic tick(input logic rdy, input int c, input int rw, input logic h, input logic v,
                       input logic f, input logic val, input logic [15:0] nf, input logic [15:0] nb);
      logic [15:0] cur_fg, cur_bg, exp;
      ready = rdy; col = 11'(c); row = 11'(rw);
      hs = h; vs = v; fr = f; cv = val; cf = nf; cb = nb;
      cur_fg = m_fg;
      cur_bg = m_bg;
      if (inwin(rdy, c, rw)) m_addr = 4'((rw - Y0) / (1 << SHIFT));
      if (m_idle && val) begin
         m_pf = nf; m_pb = nb; m_idle = 1'b0;
      end else if (!m_idle && f && !m_frp) begin
         m_fg = m_pf; m_bg = m_pb; m_idle = 1'b1;
      end
      m_frp = f;
      kq[2] = kq[1]; kq[1] = kq[0]; kq[0] = kind(rdy, c, rw);
      hq[2] = hq[1]; hq[1] = hq[0]; hq[0] = h;
      vq[2] = vq[1]; vq[1] = vq[0]; vq[0] = v;
      @(posedge vga_clk); #1;
      exp = kq[2] == 0 ? 16'h0000 : kq[2] == 2 ? cur_fg : cur_bg;
      chk($sformatf("rgb c%0d r%0d", c, rw), {o_r, o_g, o_b}, exp);
      chk("hsync", 16'(o_hs), 16'(hq[2]));
      chk("vsync", 16'(o_vs), 16'(vq[2]));
      chk("ram_addr", 16'(ram_addr), 16'(m_addr));
      chk("cfg_ready", 16'(cfg_ready), 16'(m_idle));
   endtask

   task automatic blank(input int n, input logic f);
      for (int i = 0; i < n; i++) tick(1'b0, 0, 0, 1'b1, 1'b1, f, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic scan(input int rw, input int c0, input int c1);
      for (int c = c0; c <= c1; c++) tick(1'b1, c, rw, 1'($urandom), 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      blank(3, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
      mem[0] = 16'h8001;
      model_reset();
      do_reset();
      scan(232, 300, 390);
      scan(296, 300, 390);
      scan(240, 305, 380);
      tick(1'b1, 320, 233, 1'b1, 1'b1, 1'b0, 1'b1, 16'hF800, 16'h001F);
      scan(232, 308, 380);
      blank(20, 1'b1);
      tick(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h07E0, 16'h1234);
      blank(20, 1'b1);
      scan(232, 308, 380);
      blank(5, 1'b0);
      blank(3, 1'b1);
      scan(233, 308, 380);
      blank(5, 1'b0);
      tick(1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 16'hABCD, 16'h5555);
      blank(10, 1'b1);
      blank(5, 1'b0);
      scan(232, 308, 380);
      blank(2, 1'b1);
      blank(2, 1'b0);
      scan(232, 308, 380);
      tick(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0F0F, 16'hF0F0);
      do_reset();
      blank(3, 1'b1);
      scan(232, 308, 380);
      for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
      fstate = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 19) == 0) fstate = ~fstate;
         if ($urandom_range(0, 9) == 0)
            tick(1'($urandom_range(0, 3) != 0), $urandom_range(0, 639), $urandom_range(0, 479),
                 1'($urandom), 1'($urandom), fstate, 1'($urandom_range(0, 7) == 0), 16'($urandom), 16'($urandom));
         else
            tick(1'($urandom_range(0, 3) != 0), $urandom_range(300, 390), $urandom_range(225, 305),
                 1'($urandom), 1'($urandom), fstate, 1'($urandom_range(0, 7) == 0), 16'($urandom), 16'($urandom));
      end
      blank(3, 1'b0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/vga_ram_display_module.md
# vga_ram_display_module

Pixel-generation stage directly downstream of the 640x480@60 VGA sync generator. It takes that block's Ready/HSYNC/VSYNC/Frame strobes and 0-based column/row addresses and reads a 16x16 monochrome bitmap from an external synchronous RAM (16 words x 16 bits). It drives RGB565 pixels with syncs delayed to match. Foreground/background colours are updated through a valid/ready handshake and committed only at frame boundaries, so colour changes never tear.

## Interface
Parameters:
- X0, 11'd312, left edge of bitmap window (column address).
- Y0, 11'd232, top edge of bitmap window (row address).
- SHIFT, 2, magnification as log2; each bitmap bit covers (1<<SHIFT)x(1<<SHIFT) pixels. Legal range 0..4.
- FG_INIT, 16'hFFFF, foreground colour after reset.
- BG_INIT, 16'h0000, background colour after reset.

Ports:
- vga_clk  in  1  pixel clock (25.175 MHz).
- rst  in  1  synchronous, active-high reset.
- Ready_Sig  in  1  active-video flag from the sync generator.
- HSYNC_Sig  in  1  horizontal sync, active low.
- VSYNC_Sig  in  1  vertical sync, active low.
- Frame_Sig  in  1  high during the last line of a frame.
- Column_Addr_Sig  in  11  pixel column 0..639, valid when Ready_Sig=1.
- Row_Addr_Sig  in  11  pixel row 0..479, valid when Ready_Sig=1.
- Ram_Addr  out  4  bitmap row address to the RAM.
- Ram_Data  in  16  RAM read data, valid 1 cycle after Ram_Addr is registered; bit 15 is the leftmost pixel.
- Cfg_Valid  in  1  colour update request.
- Cfg_Fg  in  16  requested foreground colour, RGB565.
- Cfg_Bg  in  16  requested background colour, RGB565.
- Cfg_Ready  out  1  block can accept a colour update.
- VGA_HSYNC  out  1  delayed HSYNC.
- VGA_VSYNC  out  1  delayed VSYNC.
- VGA_Red  out  5  red pixel component.
- VGA_Green  out  6  green pixel component.
- VGA_Blue  out  5  blue pixel component.

## Operation
- Window test (stage 1):
  - dx = Column_Addr_Sig − X0 and dy = Row_Addr_Sig − Y0, both computed in 12 bits.
  - in_win = Ready_Sig & dx ≥ 0 & dy ≥ 0 & (dx>>SHIFT) < 16 & (dy>>SHIFT) < 16.
  - Ram_Addr <= dy>>SHIFT (bits 3:0) when in_win; otherwise it holds its previous value.
  - Bit index idx = 15 − (dx>>SHIFT), registered.
- Stage 2: RAM returns Ram_Data. in_win, idx, Ready and both syncs are carried one more register stage.
- Stage 3 output:
  - Ready=0 → RGB 0. Blanking is mandatory.
  - Ready=1 and outside the window → BG colour.
  - Ready=1 and inside the window → Ram_Data[idx] ? FG : BG.
- Clipping: a window extending past column 639 or row 479 is drawn only where Ready_Sig=1. No wrap-around.
- Colour FSM:
  - IDLE: Cfg_Ready=1. Cfg_Valid & Cfg_Ready latches Cfg_Fg/Cfg_Bg into pending registers → PENDING.
  - PENDING: Cfg_Ready=0. On the rising edge of Frame_Sig (Frame_Sig=1 & registered previous value=0), the active FG/BG load from pending → IDLE.
  - An accept in the same cycle as a Frame_Sig rising edge goes to PENDING and commits at the next frame.
  - Frame_Sig held high across a whole line produces exactly one commit.
- Reset (synchronous, priority over everything):
  - FSM returns to IDLE; pending requests are discarded.
  - FG=FG_INIT, BG=BG_INIT.
  - All pipeline registers clear; Cfg_Ready=0 while rst=1.

## Timing
- Reset values: VGA_HSYNC=1, VGA_VSYNC=1, VGA_Red/Green/Blue=0, Ram_Addr=0, Cfg_Ready=0 (1 in the first cycle after rst falls).
- Pixel latency: 3 vga_clk cycles from the input address/Ready to RGB out.
- VGA_HSYNC/VGA_VSYNC are delayed by exactly 3 cycles, so the sync-to-pixel alignment of the sync generator is preserved.
- RAM contract: synchronous read, Ram_Data valid on the edge after Ram_Addr changes.
- A colour commit takes effect on the first pixel clocked out after the commit edge. That pixel is in vertical blanking, so a visible frame never mixes colours.
- Cfg_Ready deasserts the cycle after an accept and reasserts the cycle after a commit.

## Configuration
- VGA_BORDER_EN defined:
  - Pixels with Ready=1 on the 1-pixel ring just outside the window are drawn in FG.
  - The ring is columns X0−1 and X0+(16<<SHIFT), rows Y0−1 and Y0+(16<<SHIFT), clipped to the visible area. Latency is unchanged.
- Undefined: no border logic; those pixels use BG.

## Test plan
- Reset with Ready=1 at column 312, row 232 → all RGB 0, syncs 1, Cfg_Ready 0; first cycle after rst falls, Cfg_Ready=1.
- RAM word 0 = 16'h8001, SHIFT=2, X0=312, Y0=232; scan row 232 → FG 16'hFFFF at columns 312–315 and 372–375, BG 0 at 316–371 and elsewhere; each pixel 3 cycles after its address; HSYNC delayed 3 cycles.
- Row 296 (dy>>2=16) with any RAM data → BG only; Ram_Addr holds its last value.
- Cfg_Valid with Fg=16'hF800, Bg=16'h001F mid-frame → Cfg_Ready drops; old colours persist to frame end; on the Frame_Sig rise, colours switch once; Cfg_Ready rises the next cycle.
- Cfg_Valid accepted in the same cycle as the Frame_Sig rise → commit deferred to the following frame; rst asserted while PENDING → FG/BG return to FFFF/0000 and the request is discarded.
- With VGA_BORDER_EN: column 311, row 240 → FG; without it → BG.
